// File: rtl/cod_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cod_pkg (package)
//  Description : Shared definitions for the fetch front end: sequencer state
//                encoding, PC step size and default datapath widths.
//  Revision    : 1.0  initial release
// ============================================================================
package cod_pkg;

    // Default widths: byte-address PC and instruction word
    localparam int DEF_PC_W   = 8;
    localparam int DEF_INST_W = 32;

    // Byte distance between consecutive instructions
    localparam int PC_STEP    = 4;

    // Sequencer state encoding
    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

endpackage : cod_pkg
`default_nettype wire

// File: rtl/pc_skid_buf.sv
`default_nettype none
// ============================================================================
//  Module      : pc_skid_buf
//  Description : One-entry holding register for an {instruction, pc} pair that
//                returns from memory while the output register is occupied.
//  Ports       : clk, rst      clock / asynchronous active-high reset
//                load_i        capture inst_i/pc_i (entry becomes valid)
//                drain_i       entry consumed (valid clears unless reloaded)
//                flush_i       discard entry; wins over load and drain
//                inst_i, pc_i  data to capture
//                valid_o, inst_o, pc_o  held entry
//  Revision    : 1.0  initial release
// ============================================================================
module pc_skid_buf
    import cod_pkg::*;
#(
    parameter int PC_W   = DEF_PC_W,
    parameter int INST_W = DEF_INST_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              drain_i,
    input  logic              flush_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [PC_W-1:0]   pc_i,
    output logic              valid_o,
    output logic [INST_W-1:0] inst_o,
    output logic [PC_W-1:0]   pc_o
);

    logic              valid_q;
    logic [INST_W-1:0] inst_q;
    logic [PC_W-1:0]   pc_q;

    // Load and drain in the same cycle keeps the entry valid with new data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            inst_q  <= '0;
            pc_q    <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            inst_q  <= inst_i;
            pc_q    <= pc_i;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign inst_o  = inst_q;
    assign pc_o    = pc_q;

endmodule : pc_skid_buf
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pc_sequencer
//  Description : Program-counter owner and instruction-fetch sequencer. Issues
//                word reads to a 1-cycle-latency instruction memory, steps the
//                PC, and presents {inst, inst_pc} to decode over valid/ready.
//                Supports redirect with flush, halt, and a 1-entry skid buffer.
//  Ports       : clk, rst                clock / async active-high reset
//                halt                    suppress new fetches
//                redir_valid, redir_pc   redirect request and target
//                imem_en, imem_addr      memory read strobe / word address
//                imem_rdata              memory data, valid cycle after imem_en
//                inst_valid, inst_ready  decode handshake
//                inst, inst_pc           instruction and its byte address
//                fetch_cnt, stall_cnt    perf counters (PC_SEQ_PERF_EN only)
//  Config      : define PC_SEQ_PERF_EN to add the performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_sequencer
    import cod_pkg::*;
#(
    parameter int              PC_W     = DEF_PC_W,
    parameter int              INST_W   = DEF_INST_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt,
    input  logic              redir_valid,
    input  logic [PC_W-1:0]   redir_pc,
    output logic              imem_en,
    output logic [PC_W-3:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [15:0]       fetch_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    localparam logic [PC_W-1:0] ALIGN_MASK = {{(PC_W-2){1'b1}}, 2'b00};
    localparam logic [PC_W-1:0] PC_RST     = RESET_PC & ALIGN_MASK;
    localparam logic [PC_W-1:0] PC_INC     = PC_W'(PC_STEP);

    logic [1:0]        state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              inflight_q;
    logic [PC_W-1:0]   inflight_pc_q;
    logic              out_valid_q;
    logic [INST_W-1:0] out_inst_q;
    logic [PC_W-1:0]   out_pc_q;

    logic              issue;
    logic              out_free;
    logic              skid_valid;
    logic [INST_W-1:0] skid_inst;
    logic [PC_W-1:0]   skid_pc;
    logic              skid_load;
    logic              skid_drain;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_BOOT;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN:  if (halt)  state_d = ST_HALT;
            ST_HALT: if (!halt) state_d = ST_RUN;
            default: state_d = ST_BOOT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A fetch is only issued when its return is guaranteed a home: the skid
    // is empty and the output register is free or being consumed this cycle.
    assign out_free = !out_valid_q || inst_ready;

    always_comb begin
        issue = 1'b0;
        if (state_q == ST_RUN && !halt && !skid_valid && out_free && !redir_valid)
            issue = 1'b1;
    end

    // ---------------- PC and in-flight tracking ----------------
    always_comb begin
        pc_d = pc_q;
        if (redir_valid) pc_d = redir_pc & ALIGN_MASK;
        else if (issue)  pc_d = pc_q + PC_INC;
    end

    // issue is forced low by a redirect, so the in-flight read is dropped too.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= PC_RST;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= issue;
            if (issue) inflight_pc_q <= pc_q;
        end
    end

    // ---------------- Skid buffer ----------------
    // The skid drains into the output register ahead of any memory return.
    always_comb begin
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        if (!redir_valid) begin
            if (out_free) begin
                skid_drain = skid_valid;
                skid_load  = inflight_q && skid_valid;
            end else begin
                skid_load  = inflight_q;
            end
        end
    end

    pc_skid_buf #(
        .PC_W   (PC_W),
        .INST_W (INST_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .flush_i (redir_valid),
        .inst_i  (imem_rdata),
        .pc_i    (inflight_pc_q),
        .valid_o (skid_valid),
        .inst_o  (skid_inst),
        .pc_o    (skid_pc)
    );

    // ---------------- Output register ----------------
    // Only loads when free, so inst/inst_pc never move under a stall. A
    // transfer completing in a redirect cycle is honoured by decode itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_pc_q    <= '0;
        end else if (redir_valid) begin
            out_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid) begin
                out_valid_q <= 1'b1;
                out_inst_q  <= skid_inst;
                out_pc_q    <= skid_pc;
            end else if (inflight_q) begin
                out_valid_q <= 1'b1;
                out_inst_q  <= imem_rdata;
                out_pc_q    <= inflight_pc_q;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign imem_en    = issue;
    assign imem_addr  = pc_q[PC_W-1:2];
    assign inst_valid = out_valid_q;
    assign inst       = out_inst_q;
    assign inst_pc    = out_pc_q;

`ifdef PC_SEQ_PERF_EN
    // ---------------- Performance counters (free-running, wrap) ----------------
    logic [15:0] fetch_cnt_q;
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (issue)                         fetch_cnt_q <= fetch_cnt_q + 16'd1;
            if (state_q == ST_RUN && !issue)   stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign stall_cnt = stall_cnt_q;
`endif

endmodule : pc_sequencer
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_sequencer
//  Description : Scoreboard bench for pc_sequencer. Stimulus pushes expected
//                fetch addresses and delivered PCs into queues; a monitor pops
//                and compares on every imem_en and every presented instruction.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

    logic        clk;
    logic        rst;
    logic        halt;
    logic        redir_valid;
    logic [7:0]  redir_pc;
    logic        imem_en;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [7:0]  inst_pc;
`ifdef PC_SEQ_PERF_EN
    logic [15:0] fetch_cnt;
    logic [15:0] stall_cnt;
`endif

    pc_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .imem_en     (imem_en),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst        (inst),
        .inst_pc     (inst_pc)
`ifdef PC_SEQ_PERF_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory content is a fixed function of the word address
    function automatic logic [31:0] mem_word(input logic [5:0] a);
        return {2'b10, a, 8'h5A, 2'b01, a, 2'b00, ~a};
    endfunction

    always @(posedge clk) begin
        if (imem_en) imem_rdata <= mem_word(imem_addr);
    end

    int         checks = 0;
    int         errors = 0;
    int         issued = 0;
    int         base   = 0;
    logic [5:0] addr_q[$];
    logic [7:0] pc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- Monitor / scoreboard ----------------
    initial begin
        logic [5:0] ea;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (imem_en) begin
                    issued++;
                    if (addr_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_issue: got addr %0h expected none", imem_addr);
                    end else begin
                        ea = addr_q.pop_front();
                        chk("imem_addr", 32'(imem_addr), 32'(ea));
                    end
                end
                // Whatever is presented must be the next expected instruction;
                // it is retired only on a transfer, so stalls must hold it.
                if (inst_valid) begin
                    if (pc_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_inst: got pc %0h expected none", inst_pc);
                    end else begin
                        chk("inst_pc", 32'(inst_pc), 32'(pc_q[0]));
                        chk("inst", inst, mem_word(pc_q[0][7:2]));
                        if (inst_ready) void'(pc_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst         = 1'b1;
        halt        = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 8'h00;
        inst_ready  = 1'b1;
        addr_q.delete();
        pc_q.delete();
        #1;
        chk("rst_imem_en",    32'(imem_en),    32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_imem_addr",  32'(imem_addr),  32'd0);
        chk("rst_inst",       inst,            32'd0);
        chk("rst_inst_pc",    32'(inst_pc),    32'd0);
`ifdef PC_SEQ_PERF_EN
        chk("rst_fetch_cnt",  32'(fetch_cnt),  32'd0);
`endif
        tick();
        tick();
        base = issued;
        rst  = 1'b0;        // this cycle is the BOOT cycle
    endtask

    // Let n fetches issue (counted from reset), then halt and drain; an
    // optional decode stall of stall_len cycles starts when stall_at shows.
    task automatic run_fetch(input int n, input int stall_at, input int stall_len);
        int left    = 0;
        bit stalled = 1'b0;
        for (int c = 0; c < 80; c++) begin
            halt = ((issued - base) >= n);
            if (stall_at >= 0 && !stalled && inst_valid && inst_pc == stall_at[7:0]) begin
                left    = stall_len;
                stalled = 1'b1;
            end
            inst_ready = (left == 0);
            if (halt && addr_q.size() == 0 && pc_q.size() == 0) break;
            if (left > 0) begin
                @(negedge clk);
                chk("stall_no_issue", 32'(imem_en), 32'd0);
                left--;
            end
            tick();
        end
        chk("drain_addr", 32'(addr_q.size()), 32'd0);
        chk("drain_pc",   32'(pc_q.size()),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; halt = 1'b0; redir_valid = 1'b0; redir_pc = 8'h00; inst_ready = 1'b1;

        // ---- 1: boot and back-to-back fetch ----
        do_reset();
        addr_q = '{6'h00, 6'h01, 6'h02, 6'h03};
        pc_q   = '{8'h00, 8'h04, 8'h08, 8'h0C};
        @(negedge clk);
        chk("boot_no_issue", 32'(imem_en), 32'd0);
        tick();
        @(negedge clk);
        chk("first_issue", 32'(imem_en), 32'd1);
        tick();
        @(negedge clk);
        chk("no_early_valid", 32'(inst_valid), 32'd0);
        tick();
        @(negedge clk);
        chk("first_valid", 32'(inst_valid), 32'd1);
        tick();
        @(negedge clk);
        chk("b2b_valid", 32'(inst_valid), 32'd1);
        tick();
        run_fetch(4, -1, 0);

        // ---- 2: decode stall with skid fill ----
        do_reset();
        addr_q = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05};
        pc_q   = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14};
        run_fetch(6, 8, 3);

        // ---- 3: redirect with one read in flight ----
        do_reset();
        addr_q = '{6'h00, 6'h10, 6'h11};
        pc_q   = '{8'h40, 8'h44};
        tick();                         // C1: issue addr 0
        tick();                         // C2: redirect
        redir_valid = 1'b1;
        redir_pc    = 8'h42;
        @(negedge clk);
        chk("redir_no_issue", 32'(imem_en), 32'd0);
        tick();
        redir_valid = 1'b0;
        @(negedge clk);
        chk("redir_first_en", 32'(imem_en), 32'd1);
        tick();
        run_fetch(3, -1, 0);

        // ---- 4: redirect + halt in BOOT to FC, PC wrap ----
        do_reset();
        addr_q = '{6'h3F, 6'h00, 6'h01};
        pc_q   = '{8'hFC, 8'h00, 8'h04};
        halt        = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 8'hFD;
        @(negedge clk);
        chk("boot_redir_no_issue", 32'(imem_en), 32'd0);
        tick();
        redir_valid = 1'b0;
        @(negedge clk);
        chk("halt_redir_no_issue", 32'(imem_en), 32'd0);
        chk("halt_redir_addr",     32'(imem_addr), 32'h3F);
        tick();
        run_fetch(3, -1, 0);

        // ---- 5: halt while reads in flight ----
        do_reset();
        addr_q = '{6'h00, 6'h01, 6'h02, 6'h03};
        pc_q   = '{8'h00, 8'h04, 8'h08, 8'h0C};
        tick();
        tick();
        tick();                         // C3
        halt = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("halt_no_issue", 32'(imem_en), 32'd0);
            tick();
        end
        chk("halt_pc_hold", 32'(imem_addr), 32'h02);
        run_fetch(4, -1, 0);

        // ---- 6: reset with output valid and skid full ----
        do_reset();
        addr_q = '{6'h00, 6'h01, 6'h02, 6'h03};
        pc_q   = '{8'h00, 8'h04, 8'h08};
        for (int i = 0; i < 5; i++) tick();
        chk("pre_stall_pc", 32'(inst_pc), 32'h08);
        inst_ready = 1'b0;
        tick();
        #2;
        chk("pending_pc", 32'(pc_q.size()), 32'd1);
        chk("all_issued", 32'(addr_q.size()), 32'd0);
`ifdef PC_SEQ_PERF_EN
        chk("fetch_cnt", 32'(fetch_cnt), 32'd4);
`endif
        rst = 1'b1;
        #1;
        chk("async_inst_valid", 32'(inst_valid), 32'd0);
        chk("async_imem_en",    32'(imem_en),    32'd0);
        chk("async_pc",         32'(imem_addr),  32'd0);
        addr_q.delete();
        pc_q.delete();
        tick();
        tick();
        rst        = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        chk("reboot_no_issue", 32'(imem_en),    32'd0);
        chk("reboot_valid",    32'(inst_valid), 32'd0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pc_sequencer
`default_nettype wire
